// File: rtl/dtw_pkg.sv
// rtl/dtw_pkg.sv - shared types, defaults and saturation helper for the dtw front end
//
// Contents:
//   DEF_DATA_WIDTH / DEF_WORD_LEN / DEF_SQG_LEN : default stream and query geometry
//   framer_state_t                             : framer FSM states
//   sat_word(v, w)                             : clamp a signed 33-bit value to signed w-bit range
package dtw_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_WORD_LEN   = 16;
    localparam int DEF_SQG_LEN    = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } framer_state_t;

    // Result is still 33 bits wide; callers keep the low w bits, which hold
    // the clamped value in two's complement.
    function automatic logic signed [32:0] sat_word(input logic signed [32:0] v, input int w);
        logic signed [32:0] hi;
        logic signed [32:0] lo;
        hi = (33'sd1 <<< (w - 1)) - 33'sd1;
        lo = -(33'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/sqg_stream_framer_if.sv
// rtl/sqg_stream_framer_if.sv - input/output stream bundle of the query framer
//
// Signals:
//   s_tvalid/s_tready/s_tdata/s_tlast : raw sample stream into the framer
//   m_tvalid/m_tready/m_tdata/m_tuser/m_tlast : framed word stream out of the framer
// Modports:
//   slave  : framer side (consumes s_*, produces m_*)
//   master : environment side (produces s_*, consumes m_*)
interface sqg_stream_framer_if
    import dtw_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_WIDTH,
    parameter int WORD_W = DEF_WORD_LEN
);
    logic              s_tvalid;
    logic              s_tready;
    logic [DATA_W-1:0] s_tdata;
    logic              s_tlast;
    logic              m_tvalid;
    logic              m_tready;
    logic [WORD_W-1:0] m_tdata;
    logic              m_tuser;
    logic              m_tlast;

    modport slave (
        input  s_tvalid, s_tdata, s_tlast, m_tready,
        output s_tready, m_tvalid, m_tdata, m_tuser, m_tlast
    );

    modport master (
        output s_tvalid, s_tdata, s_tlast, m_tready,
        input  s_tready, m_tvalid, m_tdata, m_tuser, m_tlast
    );
endinterface

// File: rtl/sqg_scale_sat.sv
// rtl/sqg_scale_sat.sv - combinational offset subtract, arithmetic shift and saturation
//
// Ports:
//   data   in  32        raw signed sample
//   offset in  32        signed offset subtracted from the sample
//   shift  in  5         arithmetic right-shift amount
//   word   out WORD_LEN  scaled sample clamped to the signed WORD_LEN range
module sqg_scale_sat
    import dtw_pkg::*;
#(
    parameter int WORD_LEN = DEF_WORD_LEN
) (
    input  logic [31:0]         data,
    input  logic [31:0]         offset,
    input  logic [4:0]          shift,
    output logic [WORD_LEN-1:0] word
);

    // One guard bit so the subtraction can never wrap.
    logic signed [32:0] diff;
    logic signed [32:0] shifted;

    assign diff    = $signed({data[31], data}) - $signed({offset[31], offset});
    assign shifted = diff >>> shift;
    assign word    = WORD_LEN'(sat_word(shifted, WORD_LEN));

endmodule

// File: rtl/sqg_stream_framer.sv
// rtl/sqg_stream_framer.sv - scales raw samples and frames them into fixed-length queries
//
// Ports:
//   S_AXIS_clk    in   1      clock
//   S_AXIS_rst    in   1      asynchronous active-high reset
//   cfg_en        in   1      permits the start of a new query
//   cfg_offset    in   32     signed offset, latched on the first beat of a query
//   cfg_shift     in   5      arithmetic right shift, latched on the first beat
//   cfg_clr_err   in   1      pulse clearing the sticky error bits
//   bus           slave      raw sample stream in, framed word stream out
//   sample_count  out  CNT_W  samples accepted in the current query
//   busy          out  1      framer is inside a query
//   short_err     out  1      sticky: input tlast before SQG_LEN samples
//   trunc_err     out  1      sticky: input ran past SQG_LEN samples
module sqg_stream_framer
    import dtw_pkg::*;
#(
    parameter  int S_AXIS_DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int WORD_LEN          = DEF_WORD_LEN,
    parameter  int SQG_LEN           = DEF_SQG_LEN,
    localparam int CNT_W             = $clog2(SQG_LEN + 1)
) (
    input  logic                 S_AXIS_clk,
    input  logic                 S_AXIS_rst,
    input  logic                 cfg_en,
    input  logic [31:0]          cfg_offset,
    input  logic [4:0]           cfg_shift,
    input  logic                 cfg_clr_err,
    sqg_stream_framer_if.slave   bus,
    output logic [CNT_W-1:0]     sample_count,
    output logic                 busy,
    output logic                 short_err,
    output logic                 trunc_err
);

    framer_state_t        state;
    logic [31:0]          off_q;
    logic [4:0]           shift_q;
    logic [31:0]          off_use;
    logic [4:0]           shift_use;
    logic [WORD_LEN-1:0]  word;
    logic                 out_free;
    logic                 accept;
    logic [CNT_W-1:0]     cnt_inc;
    logic                 at_len;

    // The output register may take a new word when empty or being drained
    // this cycle. DRAIN never loads it, so it may always accept.
    assign out_free     = !bus.m_tvalid || bus.m_tready;
    assign bus.s_tready = (state == DRAIN)  ? 1'b1 :
                          (state == STREAM) ? out_free :
                                              (cfg_en && out_free);
    assign accept       = bus.s_tvalid && bus.s_tready;

    // The first beat of a query uses the live config; the rest use the copy
    // captured alongside that beat.
    assign off_use   = (state == IDLE) ? cfg_offset : off_q;
    assign shift_use = (state == IDLE) ? cfg_shift  : shift_q;

    assign cnt_inc = sample_count + CNT_W'(1);
    assign at_len  = (cnt_inc == CNT_W'(SQG_LEN));

    sqg_scale_sat #(
        .WORD_LEN (WORD_LEN)
    ) u_scale (
        .data   (bus.s_tdata),
        .offset (off_use),
        .shift  (shift_use),
        .word   (word)
    );

    always_ff @(posedge S_AXIS_clk or posedge S_AXIS_rst) begin
        if (S_AXIS_rst) begin
            state        <= IDLE;
            off_q        <= '0;
            shift_q      <= '0;
            bus.m_tvalid <= 1'b0;
            bus.m_tdata  <= '0;
            bus.m_tuser  <= 1'b0;
            bus.m_tlast  <= 1'b0;
            sample_count <= '0;
            busy         <= 1'b0;
            short_err    <= 1'b0;
            trunc_err    <= 1'b0;
        end else begin
            if (bus.m_tready) begin
                bus.m_tvalid <= 1'b0;
            end

            // Clears come first so that a set later in this block overrides.
            if (cfg_clr_err) begin
                short_err <= 1'b0;
                trunc_err <= 1'b0;
            end

            if (accept) begin
                case (state)
                    IDLE: begin
                        off_q        <= cfg_offset;
                        shift_q      <= cfg_shift;
                        bus.m_tvalid <= 1'b1;
                        bus.m_tdata  <= word;
                        bus.m_tuser  <= 1'b1;
                        bus.m_tlast  <= bus.s_tlast;
                        if (bus.s_tlast) begin
                            // Single-beat read: a complete, but short, query.
                            short_err <= 1'b1;
                        end else begin
                            state        <= STREAM;
                            busy         <= 1'b1;
                            sample_count <= CNT_W'(1);
                        end
                    end
                    STREAM: begin
                        bus.m_tvalid <= 1'b1;
                        bus.m_tdata  <= word;
                        bus.m_tuser  <= 1'b0;
                        bus.m_tlast  <= at_len || bus.s_tlast;
                        if (at_len) begin
                            if (bus.s_tlast) begin
                                state        <= IDLE;
                                busy         <= 1'b0;
                                sample_count <= '0;
                            end else begin
                                state        <= DRAIN;
                                trunc_err    <= 1'b1;
                                sample_count <= cnt_inc;
                            end
                        end else if (bus.s_tlast) begin
                            state        <= IDLE;
                            busy         <= 1'b0;
                            sample_count <= '0;
                            short_err    <= 1'b1;
                        end else begin
                            sample_count <= cnt_inc;
                        end
                    end
                    DRAIN: begin
                        if (bus.s_tlast) begin
                            state        <= IDLE;
                            busy         <= 1'b0;
                            sample_count <= '0;
                        end
                    end
                    default: begin
                        state        <= IDLE;
                        busy         <= 1'b0;
                        sample_count <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sqg_stream_framer.sv
// tb/tb_sqg_stream_framer.sv - directed self-checking bench for sqg_stream_framer
module tb_sqg_stream_framer;

    logic        clk;
    logic        rst;
    logic        cfg_en;
    logic [31:0] cfg_offset;
    logic [4:0]  cfg_shift;
    logic        cfg_clr_err;
    logic [2:0]  sample_count;
    logic        busy;
    logic        short_err;
    logic        trunc_err;

    int checks = 0;
    int errors = 0;

    logic [15:0] out_d[$];
    logic        out_u[$];
    logic        out_l[$];
    logic [15:0] exp_d[8];

    logic        stalled;
    logic [17:0] held;

    sqg_stream_framer_if bus ();

    sqg_stream_framer dut (
        .S_AXIS_clk   (clk),
        .S_AXIS_rst   (rst),
        .cfg_en       (cfg_en),
        .cfg_offset   (cfg_offset),
        .cfg_shift    (cfg_shift),
        .cfg_clr_err  (cfg_clr_err),
        .bus          (bus.slave),
        .sample_count (sample_count),
        .busy         (busy),
        .short_err    (short_err),
        .trunc_err    (trunc_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every completed output transfer; sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.m_tvalid && bus.m_tready) begin
            out_d.push_back(bus.m_tdata);
            out_u.push_back(bus.m_tuser);
            out_l.push_back(bus.m_tlast);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one beat and hold it until accepted; returns 1 time unit after the accepting edge.
    task automatic send(input logic [31:0] d, input logic l);
        int n;
        n = 0;
        bus.s_tvalid = 1'b1;
        bus.s_tdata  = d;
        bus.s_tlast  = l;
        forever begin
            @(negedge clk);
            if (bus.s_tready) break;
            n++;
            if (n > 50) begin
                checks++;
                errors++;
                $error("FAIL send_timeout observed s_tready=0 expected 1 for data %0h", d);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.s_tvalid = 1'b0;
        bus.s_tlast  = 1'b0;
    endtask

    task automatic clear_outputs();
        out_d.delete();
        out_u.delete();
        out_l.delete();
    endtask

    task automatic check_frame(input string tag, input int n);
        chk({tag, "_count"}, out_d.size(), n);
        for (int i = 0; i < n && i < out_d.size(); i++) begin
            chk({tag, "_data"}, out_d[i], exp_d[i]);
            chk({tag, "_user"}, out_u[i], (i == 0));
            chk({tag, "_last"}, out_l[i], (i == n - 1));
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst          = 1'b1;
        cfg_en       = 1'b0;
        cfg_offset   = 32'd0;
        cfg_shift    = 5'd0;
        cfg_clr_err  = 1'b0;
        bus.s_tvalid = 1'b0;
        bus.s_tdata  = 32'd0;
        bus.s_tlast  = 1'b0;
        bus.m_tready = 1'b1;
        stalled      = 1'b0;
        held         = '0;

        // Reset state
        #1;
        chk("rst_mvalid", bus.m_tvalid, 0);
        chk("rst_count", sample_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_errs", {short_err, trunc_err}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("idle_noen_sready", bus.s_tready, 0);
        cfg_en = 1'b1;
        #1;
        chk("idle_en_sready", bus.s_tready, 1);

        // Basic framing
        clear_outputs();
        send(32'd10, 1'b0);
        chk("t1_lat_valid", bus.m_tvalid, 1);
        chk("t1_lat_data", bus.m_tdata, 16'd10);
        chk("t1_lat_user", bus.m_tuser, 1);
        chk("t1_busy", busy, 1);
        chk("t1_count1", sample_count, 1);
        send(32'd11, 1'b0);
        send(32'd12, 1'b0);
        send(32'd13, 1'b0);
        chk("t1_count4", sample_count, 4);
        send(32'd14, 1'b1);
        idle_cycles(2);
        for (int i = 0; i < 5; i++) exp_d[i] = 16'(10 + i);
        check_frame("t1", 5);
        chk("t1_errs", {short_err, trunc_err}, 0);
        chk("t1_busy_end", busy, 0);
        chk("t1_count_end", sample_count, 0);

        // Scaling / saturation with config latched on the first beat
        clear_outputs();
        cfg_offset = 32'd100;
        cfg_shift  = 5'd2;
        send(32'h0000_0064, 1'b0);
        cfg_offset = 32'd0;
        cfg_shift  = 5'd0;
        send(32'h0000_01F4, 1'b0);
        send(32'h7FFF_FFFF, 1'b0);
        send(32'h8000_0000, 1'b0);
        send(32'hFFFF_FF9C, 1'b1);
        idle_cycles(2);
        exp_d[0] = 16'h0000;
        exp_d[1] = 16'h0064;
        exp_d[2] = 16'h7FFF;
        exp_d[3] = 16'h8000;
        exp_d[4] = 16'hFFCE;
        check_frame("t2", 5);

        // Short query, then clear, then set-and-clear in the same cycle
        clear_outputs();
        send(32'd1, 1'b0);
        send(32'd2, 1'b0);
        send(32'd3, 1'b1);
        idle_cycles(2);
        for (int i = 0; i < 3; i++) exp_d[i] = 16'(1 + i);
        check_frame("t3", 3);
        chk("t3_short", short_err, 1);
        chk("t3_trunc", trunc_err, 0);
        chk("t3_busy", busy, 0);
        cfg_clr_err = 1'b1;
        @(posedge clk);
        #1;
        cfg_clr_err = 1'b0;
        chk("t3_clr", short_err, 0);
        bus.s_tvalid = 1'b1;
        bus.s_tdata  = 32'd7;
        bus.s_tlast  = 1'b1;
        cfg_clr_err  = 1'b1;
        @(negedge clk);
        chk("t3_single_sready", bus.s_tready, 1);
        @(posedge clk);
        #1;
        bus.s_tvalid = 1'b0;
        bus.s_tlast  = 1'b0;
        cfg_clr_err  = 1'b0;
        chk("t3_set_wins", short_err, 1);
        chk("t3_single_out", {bus.m_tvalid, bus.m_tuser, bus.m_tlast, bus.m_tdata}, {3'b111, 16'd7});
        chk("t3_single_busy", busy, 0);
        cfg_clr_err = 1'b1;
        @(posedge clk);
        #1;
        cfg_clr_err = 1'b0;
        idle_cycles(1);

        // Truncation
        clear_outputs();
        for (int i = 0; i < 8; i++) begin
            send(32'(20 + i), (i == 7));
            if (i == 5) chk("t4_drain_busy", busy, 1);
        end
        idle_cycles(2);
        for (int i = 0; i < 5; i++) exp_d[i] = 16'(20 + i);
        check_frame("t4", 5);
        chk("t4_trunc", trunc_err, 1);
        chk("t4_short", short_err, 0);
        chk("t4_busy", busy, 0);
        chk("t4_count", sample_count, 0);
        cfg_clr_err = 1'b1;
        @(posedge clk);
        #1;
        cfg_clr_err = 1'b0;
        chk("t4_clr", trunc_err, 0);

        // Backpressure with m_tready pattern 1,0,0,1,...
        clear_outputs();
        fork
            begin
                send(32'd10, 1'b0);
                send(32'd11, 1'b0);
                send(32'd12, 1'b0);
                send(32'd13, 1'b0);
                send(32'd14, 1'b1);
            end
            begin
                for (int i = 0; i < 60 && out_d.size() < 5; i++) begin
                    bus.m_tready = ((i % 4) == 0) || ((i % 4) == 3);
                    @(negedge clk);
                    if (stalled) begin
                        chk("t5_hold", {bus.m_tvalid, bus.m_tdata, bus.m_tuser, bus.m_tlast}, {1'b1, held});
                    end
                    if (bus.m_tvalid && !bus.m_tready) begin
                        stalled = 1'b1;
                        held    = {bus.m_tdata, bus.m_tuser, bus.m_tlast};
                        chk("t5_sready_stall", bus.s_tready, 0);
                    end else begin
                        stalled = 1'b0;
                    end
                    @(posedge clk);
                    #1;
                end
                bus.m_tready = 1'b1;
                stalled = 1'b0;
            end
        join
        idle_cycles(2);
        for (int i = 0; i < 5; i++) exp_d[i] = 16'(10 + i);
        check_frame("t5", 5);
        chk("t5_errs", {short_err, trunc_err}, 0);

        // Asynchronous reset mid-query
        clear_outputs();
        send(32'd40, 1'b0);
        send(32'd41, 1'b0);
        chk("t6_pre_valid", bus.m_tvalid, 1);
        chk("t6_pre_count", sample_count, 2);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", bus.m_tvalid, 0);
        chk("t6_rst_count", sample_count, 0);
        chk("t6_rst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_outputs();
        for (int i = 0; i < 5; i++) send(32'(30 + i), (i == 4));
        idle_cycles(2);
        for (int i = 0; i < 5; i++) exp_d[i] = 16'(30 + i);
        check_frame("t6", 5);
        chk("t6_errs", {short_err, trunc_err}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sqg_stream_framer.md
Name: sqg_stream_framer

Overview:
- Upstream stage of the zynq_dtw core.
- Accepts raw 32-bit nanopore signal samples on an AXI-Stream slave.
- Per sample: subtracts a programmable offset, arithmetic-right-shifts, and saturates to signed WORD_LEN.
- Frames exactly SQG_LEN samples per query and emits them on an AXI-Stream master, with tuser on the first beat and tlast on the last.
- Flags short and over-length queries in sticky error bits readable through the AXI-Lite register file.

Parameters:
- S_AXIS_DATA_WIDTH, 32, input stream data width.
- WORD_LEN, 16, output sample width (signed two's complement).
- SQG_LEN, 5, samples per query; must be ≥ 2.

Ports:
- S_AXIS_clk  in  1  clock.
- S_AXIS_rst  in  1  asynchronous, active-high reset.
- cfg_en  in  1  permits the start of a new query.
- cfg_offset  in  32  signed offset subtracted from every sample.
- cfg_shift  in  5  arithmetic right-shift amount.
- cfg_clr_err  in  1  one-cycle pulse; clears the sticky error bits.
- s_tvalid  in  1  input beat valid.
- s_tready  out  1  input ready.
- s_tdata  in  S_AXIS_DATA_WIDTH  raw signed sample.
- s_tlast  in  1  last raw sample of the read.
- m_tvalid  out  1  output beat valid.
- m_tready  in  1  output ready.
- m_tdata  out  WORD_LEN  scaled, saturated sample.
- m_tuser  out  1  first sample of a query.
- m_tlast  out  1  last sample of a query.
- sample_count  out  clog2(SQG_LEN+1)  samples accepted in the current query.
- busy  out  1  state != IDLE.
- short_err  out  1  sticky: input tlast arrived before SQG_LEN samples.
- trunc_err  out  1  sticky: input exceeded SQG_LEN samples.

Behaviour:
- Reset (async, immediate): all outputs are 0; state=IDLE; output register empty.
- Output stage: one register, load = s_tvalid & s_tready.
  - s_tready = (!m_tvalid | m_tready) when in IDLE&cfg_en or in STREAM; s_tready = 1 in DRAIN; s_tready = 0 in IDLE&!cfg_en.
  - Latency is 1 cycle. Full throughput: one beat per cycle when m_tready=1.
  - m_tdata/m_tuser/m_tlast stay stable while m_tvalid & !m_tready.
- Arithmetic, signed throughout:
  - diff = sext33(s_tdata) − sext33(off).
  - sh = diff >>> shift.
  - m_tdata = sh clamped to [−2^(WORD_LEN−1), 2^(WORD_LEN−1)−1].
- Config latching:
  - On the first accepted beat of a query, cfg_offset/cfg_shift are latched, and that beat uses the live values.
  - All later beats of the query use the latched values.
  - Mid-query cfg changes do not affect the current query.
- State machine:
  - IDLE → STREAM on the first accepted beat (!s_tlast): emit with tuser=1; sample_count=1.
  - IDLE, first beat has s_tlast=1: emit with tuser=1, tlast=1; set short_err; stay IDLE.
  - STREAM, accept beat: sample_count+1.
    - If new count == SQG_LEN: emit tlast=1. If s_tlast=1 → IDLE (clean end); else → DRAIN and set trunc_err.
    - Else if s_tlast=1: emit tlast=1, set short_err → IDLE.
  - DRAIN: beats are accepted and discarded with no output; trunc_err is set on entry only. The accepted beat with s_tlast=1 → IDLE.
  - sample_count clears to 0 on entering IDLE.
  - Deasserting cfg_en mid-query has no effect until IDLE.
- Sticky errors:
  - Cleared by cfg_clr_err.
  - A set in the same cycle as cfg_clr_err wins: the bit reads 1 next cycle.
- Backpressure: with m_tready held low and m_tvalid=1, s_tready=0 in IDLE/STREAM; no beat is lost or duplicated.
- Reset mid-query: output is discarded; the next query starts fresh with tuser=1.

Decomposition:
- Shared package dtw_pkg holds:
  - WORD_LEN, SQG_LEN, S_AXIS_DATA_WIDTH defaults.
  - Framer state enum (IDLE, STREAM, DRAIN).
  - Saturation bounds function sat_word(signed[32:0]).
- One natural sub-module: sqg_scale_sat, a combinational subtract/shift/saturate datapath. It is instantiated once, ahead of the output register.

Test Plan:
- Basic framing (WORD_LEN=16, SQG_LEN=5, off=0, shift=0):
  - Stimulus: inputs 10,11,12,13,14 with s_tlast on 14, m_tready=1.
  - Required: outputs 10..14; tuser only on 10, tlast only on 14; each output 1 cycle after acceptance; short_err=trunc_err=0; busy returns to 0.
- Scaling/saturation (off=100, shift=2):
  - Stimulus: inputs 0x00000064, 0x000001F4, 0x7FFFFFFF, 0x80000000, 0xFFFFFF9C.
  - Required: outputs 0, 100, 0x7FFF, 0x8000, 0xFFCE (−50).
- Short query:
  - Stimulus: 3 beats with s_tlast on the 3rd.
  - Required: tlast on the 3rd output; short_err=1.
  - Then cfg_clr_err pulse → short_err=0 next cycle.
- Truncation:
  - Stimulus: 8 beats, s_tlast on the 8th.
  - Required: exactly 5 outputs, tlast on the 5th; beats 6–8 accepted with no output; trunc_err=1; back to IDLE after beat 8.
- Backpressure:
  - Stimulus: 5-beat query with m_tready toggling 1,0,0,1,…
  - Required: data/flags held while stalled; s_tready=0 while the register is full and m_tready=0; output sequence identical to test 1.
- Async reset mid-query:
  - Stimulus: assert S_AXIS_rst after 2 beats.
  - Required: m_tvalid=0 without waiting for a clock edge; sample_count=0.
  - Next query's first beat carries tuser=1.
